// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC, single-outstanding IMEM fetch with one-entry skid buffer, IF/ID register
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write_i,
  input  logic        ifid_write_i,
  input  logic        ifid_flush_n_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o
);
  typedef enum logic [1:0] {REQ, BUF, DROP} state_t;
  state_t      state;
  logic [31:0] pc, buffer, pend_pc, pc4, load_data;
  logic        advance, load_real, bubble;
  always_comb begin
    pc4       = pc + 32'd4;
    advance   = pc_write_i & ifid_write_i;
    load_real = ifid_flush_n_i & ~redirect_i & advance &
                ((state == BUF) | ((state == REQ) & imem_ack_i));
    load_data = (state == BUF) ? buffer : imem_rdata_i;
    // a writable IF/ID with nothing real to load takes a bubble
    bubble    = ~ifid_flush_n_i | (ifid_write_i & ~load_real);
  end
  assign imem_req_o  = ~reset & (state != BUF);
  assign imem_addr_o = pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= REQ;
      pc           <= RESET_PC;
      buffer       <= '0;
      pend_pc      <= '0;
      ifid_instr_o <= NOP_INSTR;
      ifid_pc4_o   <= '0;
      ifid_valid_o <= 1'b0;
    end else begin
      if (bubble) begin
        ifid_instr_o <= NOP_INSTR;
        ifid_pc4_o   <= '0;
        ifid_valid_o <= 1'b0;
      end else if (load_real) begin
        ifid_instr_o <= load_data;
        ifid_pc4_o   <= pc4;
        ifid_valid_o <= 1'b1;
      end
      case (state)
        REQ:
          if (imem_ack_i) begin
            if (redirect_i) pc <= redirect_pc_i;
            else if (load_real) pc <= pc4;
            else begin
              buffer <= imem_rdata_i;
              state  <= BUF;
            end
          end else if (redirect_i) begin
            pend_pc <= redirect_pc_i;
            state   <= DROP;
          end
        BUF:
          if (redirect_i) begin
            pc    <= redirect_pc_i;
            state <= REQ;
          end else if (load_real) begin
            pc    <= pc4;
            state <= REQ;
          end
        DROP:
          if (imem_ack_i) begin
            pc    <= redirect_i ? redirect_pc_i : pend_pc;
            state <= REQ;
          end else if (redirect_i) pend_pc <= redirect_pc_i;
        default: state <= REQ;
      endcase
    end
  end
endmodule
